// File: rtl/uart_sector_buf.sv
// rtl/uart_sector_buf.sv - UART byte stream packed into ping-pong sector banks for the SD writer
// Fill side writes one bank while the read side serves the other; idle partial sectors get padded.
module uart_sector_buf #(
  parameter int          SECTOR_BYTES   = 512,
  parameter logic [31:0] START_SECTOR   = 32'd0,
  parameter int          TIMEOUT_CYCLES = 2_500_000,
  parameter logic [7:0]  PAD_BYTE       = 8'h00
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [7:0]  pi_data,
  input  logic        pi_flag,
  input  logic        wr_busy,
  input  logic        wr_req,
  output logic        wr_start,
  output logic [31:0] wr_sec_addr,
  output logic [7:0]  wr_data,
  output logic        wr_done,
  output logic        overflow,
  output logic [15:0] sec_cnt
);

  localparam int               PTR_W     = $clog2(SECTOR_BYTES);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(SECTOR_BYTES - 1);
  localparam bit               PAD_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0]      IDLE_LAST = PAD_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  typedef enum logic [1:0] {F_FILL, F_PAD, F_WAIT} fill_state_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_XFER, R_DONE} rd_state_t;

  logic [7:0] mem [0:2*SECTOR_BYTES-1];

  fill_state_t      f_state, f_next;
  rd_state_t        r_state, r_next;
  logic             fill_bank, rd_bank;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [31:0]      idle_cnt;
  logic [1:0]       bank_full;
  logic             other_full, mem_we, fill_last, swap, drop, rd_en, rd_done;
  logic [7:0]       mem_wdata;

  assign other_full = bank_full[~fill_bank];
  assign rd_done    = (r_state == R_DONE);
  assign wr_start   = (r_state == R_START);
  assign wr_done    = rd_done;

  always_comb begin
    f_next    = f_state;
    mem_we    = 1'b0;
    mem_wdata = pi_data;
    drop      = 1'b0;
    case (f_state)
      F_FILL: begin
        if (pi_flag)
          mem_we = 1'b1;
        else if (PAD_EN && wr_ptr != '0 && idle_cnt == IDLE_LAST)
          f_next = F_PAD;
      end
      F_PAD: begin
        mem_we    = 1'b1;
        mem_wdata = PAD_BYTE;
        drop      = pi_flag;
      end
      F_WAIT: begin
        drop = pi_flag;
        if (!other_full)
          f_next = F_FILL;
      end
      default: f_next = F_FILL;
    endcase
    fill_last = mem_we && (wr_ptr == PTR_LAST);
    if (fill_last)
      f_next = other_full ? F_WAIT : F_FILL;
    swap = (fill_last || f_state == F_WAIT) && !other_full;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      f_state   <= F_FILL;
      fill_bank <= 1'b0;
      wr_ptr    <= '0;
      idle_cnt  <= 32'd0;
      bank_full <= 2'b00;
      overflow  <= 1'b0;
    end else begin
      f_state <= f_next;
      if (mem_we)
        wr_ptr <= fill_last ? '0 : wr_ptr + PTR_W'(1);
      if (swap)
        fill_bank <= ~fill_bank;
      if (f_state != F_FILL || pi_flag || wr_ptr == '0)
        idle_cnt <= 32'd0;
      else
        idle_cnt <= idle_cnt + 32'd1;
      // fill never targets a full bank, so set and clear always hit different bits
      if (fill_last)
        bank_full[fill_bank] <= 1'b1;
      if (rd_done)
        bank_full[rd_bank] <= 1'b0;
      if (drop)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (mem_we)
      mem[{fill_bank, wr_ptr}] <= mem_wdata;
  end

  always_comb begin
    r_next = r_state;
    rd_en  = 1'b0;
    case (r_state)
      R_IDLE:  if (bank_full[rd_bank] && !wr_busy) r_next = R_START;
      R_START: r_next = R_XFER;
      R_XFER: begin
        if (wr_req) begin
          rd_en = 1'b1;
          if (rd_ptr == PTR_LAST)
            r_next = R_DONE;
        end
      end
      R_DONE:  r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // banks fill strictly alternately, so serving alternately keeps fill order
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= R_IDLE;
      rd_bank     <= 1'b0;
      rd_ptr      <= '0;
      wr_data     <= 8'h00;
      wr_sec_addr <= START_SECTOR;
      sec_cnt     <= 16'd0;
    end else begin
      r_state <= r_next;
      if (r_state == R_START)
        rd_ptr <= '0;
      else if (rd_en)
        rd_ptr <= rd_ptr + PTR_W'(1);
      if (rd_en)
        wr_data <= mem[{rd_bank, rd_ptr}];
      if (rd_done) begin
        rd_bank     <= ~rd_bank;
        wr_sec_addr <= wr_sec_addr + 32'd1;
        sec_cnt     <= sec_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_sector_buf.sv
// tb/tb_uart_sector_buf.sv - scoreboard bench for uart_sector_buf
// Bytes are queued as they are sent and popped as the DUT serves them.
module tb_uart_sector_buf;

  localparam int SB = 512;
  localparam int TO = 100;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [7:0]  pi_data = 8'h00;
  logic        pi_flag = 1'b0;
  logic        wr_busy = 1'b0;
  logic        wr_req = 1'b0;
  logic        wr_start, wr_done, overflow;
  logic [31:0] wr_sec_addr;
  logic [7:0]  wr_data;
  logic [15:0] sec_cnt;

  int tests = 0;
  int fails = 0;
  logic [7:0]  sb[$];
  logic [31:0] exp_addr = 32'd0;
  logic [15:0] exp_cnt = 16'd0;

  uart_sector_buf #(
    .SECTOR_BYTES(SB), .START_SECTOR(32'd0), .TIMEOUT_CYCLES(TO), .PAD_BYTE(8'h00)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pi_data(pi_data), .pi_flag(pi_flag),
    .wr_busy(wr_busy), .wr_req(wr_req), .wr_start(wr_start), .wr_sec_addr(wr_sec_addr),
    .wr_data(wr_data), .wr_done(wr_done), .overflow(overflow), .sec_cnt(sec_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit push);
    pi_data = b;
    pi_flag = 1'b1;
    if (push) sb.push_back(b);
    step();
    pi_flag = 1'b0;
    repeat (gap - 1) step();
  endtask

  task automatic send_seq(input int n, input int base, input int gap);
    for (int i = 0; i < n; i++) send_byte(8'(base + i), gap, 1'b1);
  endtask

  task automatic read_sector(input int n, input int budget);
    int waited = 0;
    logic [7:0] e;
    while (wr_start !== 1'b1 && waited < budget) begin
      step();
      waited++;
    end
    tests++;
    if (wr_start !== 1'b1) begin
      fails++;
      $display("FAIL wr_start_wait got %b after %0d cycles, required 1", wr_start, waited);
      return;
    end
    tests++;
    if (wr_sec_addr !== exp_addr) begin
      fails++;
      $display("FAIL wr_sec_addr got %0d required %0d", wr_sec_addr, exp_addr);
    end
    step();
    tests++;
    if (wr_start !== 1'b0) begin
      fails++;
      $display("FAIL wr_start_pulse got %b required 0", wr_start);
    end
    for (int i = 0; i <= n; i++) begin
      if (i > 0) begin
        e = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        tests++;
        if (wr_data !== e) begin
          fails++;
          $display("FAIL wr_data[%0d] got %h required %h", i - 1, wr_data, e);
        end
      end
      if (n == SB && (i == n || i == n - 1)) begin
        tests++;
        if (wr_done !== (i == n)) begin
          fails++;
          $display("FAIL wr_done[%0d] got %b required %b", i, wr_done, (i == n));
        end
      end
      if (i < n) begin
        wr_req = 1'b1;
        step();
      end
    end
    wr_req = 1'b0;
    if (n == SB) begin
      step();
      exp_addr = exp_addr + 32'd1;
      exp_cnt  = exp_cnt + 16'd1;
      tests++;
      if (sec_cnt !== exp_cnt) begin
        fails++;
        $display("FAIL sec_cnt got %0d required %0d", sec_cnt, exp_cnt);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    tests++;
    if (wr_start !== 1'b0 || wr_sec_addr !== 32'd0 || wr_data !== 8'h00 ||
        wr_done !== 1'b0 || overflow !== 1'b0 || sec_cnt !== 16'd0) begin
      fails++;
      $display("FAIL %s got start=%b addr=%0d data=%h done=%b ovf=%b cnt=%0d required all zero",
               tag, wr_start, wr_sec_addr, wr_data, wr_done, overflow, sec_cnt);
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    sys_rst_n = 1'b1;
    step();
    check_reset_outputs("reset_values");
  endtask

  task automatic test_single_sector();
    fork
      send_seq(SB, 0, 4);
      read_sector(SB, SB * 4 + 50);
    join
    tests++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL single_overflow got %b required 0", overflow);
    end
  endtask

  task automatic test_back_to_back();
    wr_busy = 1'b1;
    send_seq(2 * SB, 8'h40, 2);
    repeat (5) step();
    wr_busy = 1'b0;
    read_sector(SB, 20);
    read_sector(SB, 20);
    tests++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL b2b_overflow got %b required 0", overflow);
    end
  endtask

  task automatic test_overflow();
    wr_busy = 1'b1;
    send_seq(2 * SB, 8'h11, 2);
    repeat (3) step();
    send_byte(8'hEE, 2, 1'b0);
    tests++;
    if (overflow !== 1'b1) begin
      fails++;
      $display("FAIL overflow_set got %b required 1", overflow);
    end
    wr_busy = 1'b0;
    read_sector(SB, 20);
    read_sector(SB, 20);
    fork
      send_seq(SB, 8'hEF, 1);
      read_sector(SB, SB + 50);
    join
    tests++;
    if (overflow !== 1'b1) begin
      fails++;
      $display("FAIL overflow_sticky got %b required 1", overflow);
    end
  endtask

  task automatic test_padding();
    fork
      begin
        send_byte(8'hA1, 4, 1'b1);
        send_byte(8'hA2, 4, 1'b1);
        send_byte(8'hA3, 4, 1'b1);
        for (int i = 0; i < SB - 3; i++) sb.push_back(8'h00);
      end
      read_sector(SB, TO + SB + 100);
    join
  endtask

  task automatic test_reset_mid();
    bit saw_done = 1'b0;
    fork
      send_seq(SB, 8'h80, 1);
      read_sector(200, SB + 50);
    join
    sys_rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset_values");
    repeat (3) step();
    sys_rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (wr_done !== 1'b0) saw_done = 1'b1;
    end
    tests++;
    if (saw_done) begin
      fails++;
      $display("FAIL mid_reset_no_done got 1 required 0");
    end
    sb.delete();
    exp_addr = 32'd0;
    exp_cnt  = 16'd0;
    fork
      send_seq(SB, 8'h33, 1);
      read_sector(SB, SB + 50);
    join
  endtask

  task automatic test_extra_req();
    logic [7:0] last = wr_data;
    for (int i = 0; i < 5; i++) begin
      wr_req = 1'b1;
      step();
      tests++;
      if (wr_data !== last || wr_done !== 1'b0) begin
        fails++;
        $display("FAIL extra_req[%0d] got data=%h done=%b required data=%h done=0",
                 i, wr_data, wr_done, last);
      end
    end
    wr_req = 1'b0;
    tests++;
    if (sec_cnt !== exp_cnt) begin
      fails++;
      $display("FAIL extra_req_cnt got %0d required %0d", sec_cnt, exp_cnt);
    end
    fork
      send_seq(SB, 8'h5A, 1);
      read_sector(SB, SB + 50);
    join
  endtask

  initial begin
    test_reset();
    test_single_sector();
    test_back_to_back();
    test_overflow();
    test_padding();
    test_reset_mid();
    test_extra_req();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

endmodule

// File: doc/uart_sector_buf.md
Name: uart_sector_buf

Overview:
- Sits directly downstream of the UART receiver, consuming its byte stream (8-bit data plus 1-cycle valid strobe).
- Packs bytes into SD-sector-sized blocks using two ping-pong banks.
- Hands each full block to the SD write controller with a start pulse and a sector address, then serves bytes on request.
- Pads a partial sector with a fill byte when the line goes idle, so trailing data reaches the card.

Parameters:
SECTOR_BYTES, 512, bytes per sector/bank; power of two, 16..4096
START_SECTOR, 0, SD sector address of the first block emitted
TIMEOUT_CYCLES, 2_500_000, idle sys_clk cycles before a partial sector is padded; 0 disables padding
PAD_BYTE, 8'h00, fill value used for padding

Ports:
sys_clk  in  1  system clock, all logic on posedge
sys_rst_n  in  1  asynchronous, active-low reset
pi_data  in  8  received byte from UART receiver
pi_flag  in  1  1-cycle strobe; pi_data valid this cycle
wr_busy  in  1  SD writer busy; no new wr_start while high
wr_req  in  1  SD writer requests next byte of current sector
wr_start  out  1  1-cycle pulse: a sector is ready for transfer
wr_sec_addr  out  32  sector address, valid from wr_start until sector done
wr_data  out  8  sector byte, valid the cycle after the matching wr_req
wr_done  out  1  1-cycle pulse after the last byte of a sector is served
overflow  out  1  sticky: at least one input byte was dropped
sec_cnt  out  16  number of sectors fully served (wraps at 65535)

Behaviour:
- Reset values: wr_start=0, wr_sec_addr=START_SECTOR, wr_data=0, wr_done=0, overflow=0, sec_cnt=0.
- Reset internal state: both banks free, fill bank=0, fill pointer=0, idle counter=0, both FSMs in initial state.
- Asynchronous reset mid-transfer aborts everything; buffered data is lost and no pulse is emitted.
- Fill FSM states: F_FILL, F_PAD, F_WAIT.
  - F_FILL: on pi_flag, write pi_data to fill bank at fill pointer, then increment the pointer.
  - F_FILL: a write at index SECTOR_BYTES-1 marks the bank full and pending, and resets the pointer to 0.
  - F_FILL, after a bank becomes full: swap to the other bank if it is free, else go to F_WAIT.
  - Idle counter: clears on every pi_flag and while the pointer is 0; otherwise increments.
  - When idle counter = TIMEOUT_CYCLES-1 and TIMEOUT_CYCLES != 0: go to F_PAD.
  - F_PAD: write PAD_BYTE one per cycle until the bank is full, then apply the same full handling as F_FILL.
  - F_PAD: pi_flag bytes arriving are dropped and set overflow.
  - F_WAIT: pi_flag bytes are dropped and set overflow.
  - F_WAIT: when the other bank is freed, swap banks and return to F_FILL with pointer 0.
  - A byte arriving in the same cycle the other bank frees is still dropped; the swap takes effect next cycle.
- Read FSM states: R_IDLE, R_START, R_XFER, R_DONE.
  - R_IDLE to R_START: when a bank is pending and wr_busy=0. The oldest pending bank is chosen; banks are served in fill order.
  - R_START: assert wr_start for exactly 1 cycle with wr_sec_addr stable, then go to R_XFER with read pointer 0.
  - R_XFER: each wr_req reads bank[read pointer] into wr_data on the next cycle (1-cycle latency), then increments the pointer.
  - R_XFER: wr_req on consecutive cycles is allowed (1 byte/cycle).
  - R_XFER: after the SECTOR_BYTES-th wr_req, go to R_DONE. Further wr_req are ignored until the next wr_start; wr_data holds its last value.
  - R_DONE: pulse wr_done 1 cycle (aligned with the last wr_data), free the bank, wr_sec_addr += 1 (32-bit wrap), sec_cnt += 1, return to R_IDLE.
  - wr_req in R_IDLE or R_START is ignored.
- Simultaneous fill-write and read in different banks are independent.
- The same bank is never filled and read at once.
- Memory: two SECTOR_BYTES x 8 arrays (or one 2*SECTOR_BYTES array), 1 write port and 1 registered read port; suitable for block RAM.

Test Plan:
- Reset, then send 512 bytes 0x00..0xFF,0x00..0xFF via pi_flag every 4 cycles -> single wr_start, wr_sec_addr=0. With wr_req every cycle, wr_data yields the same 512 bytes; wr_done pulses; sec_cnt=1.
- Send 1024 bytes with wr_busy=1 held until both banks are full, then release -> two sectors served in order at addresses 0 and 1, data intact, overflow=0.
- With both banks pending and wr_busy=1, send 1 extra byte -> overflow=1 and stays 1. After draining, the next sector starts with the byte following the dropped one.
- TIMEOUT_CYCLES=100: send 3 bytes 0xA1,0xA2,0xA3, then idle -> after 100 idle cycles, padding fills the sector. The sector reads as A1 A2 A3 followed by 509 x 0x00.
- Read only 200 bytes, assert sys_rst_n=0 mid-transfer, then release -> all outputs at reset values, no wr_done. The next full sector uses wr_sec_addr=START_SECTOR.
- Issue wr_req 5 extra times after wr_done -> no pointer movement, wr_data unchanged, no second wr_done.
